run_sequencer: RTL

- Sequences one program run of the single-cycle core.
- Holds the core in reset, releases it on a host start request, and counts executed cycles until the core signals done or a watchdog limit expires.
- Arbitrates the data memory write port: the host owns it while the core is idle or finished, and the core owns it during a run.
- Sits between the testbench/host and the core top level; it drives the core's reset and clock enable.

---
 rtl/run_seq_pkg.sv | 17 +
 rtl/mem_port_arb.sv | 52 +++++
 rtl/run_sequencer.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/run_seq_pkg.sv
// Shared types and default constants for the run sequencer.
// Contents: run_state_e (FSM state encoding), CNT_W_DEF (cycle counter width),
//           MAX_CYCLES_DEF (watchdog limit default).
package run_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    RUN,
    FIN,
    TOUT
  } run_state_e;

  localparam int          CNT_W_DEF      = 16;
  localparam int unsigned MAX_CYCLES_DEF = 32'h0000_FFFF;

endpackage

// File: rtl/mem_port_arb.sv
// Data memory write-port arbiter between the host and the core.
// Ports: clk/reset (sync, active-high); busy selects the owner (host when low);
//        host_*/core_* write requests in; mem_* muxed write port out;
//        host_gnt = host owns the port; host_drop = registered pulse, a host write was lost.
module mem_port_arb #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          busy,
  input  logic          host_wr_en,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  input  logic          core_wr_en,
  input  logic [AW-1:0] core_addr,
  input  logic [DW-1:0] core_wdata,
  output logic          mem_wr_en,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          host_gnt,
  output logic          host_drop
);

  assign host_gnt = !busy;

  // Pure mux: the non-owner's write enable never reaches the memory.
  always_comb begin
    mem_wr_en = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (host_gnt) begin
      mem_wr_en = host_wr_en;
      mem_addr  = host_addr;
      mem_wdata = host_wdata;
    end else begin
      mem_wr_en = core_wr_en;
      mem_addr  = core_addr;
      mem_wdata = core_wdata;
    end
  end

  // A host write while the core owns the port is discarded; flag it one cycle later.
  always_ff @(posedge clk) begin
    if (reset) begin
      host_drop <= 1'b0;
    end else begin
      host_drop <= host_wr_en && !host_gnt;
    end
  end

endmodule

// File: rtl/run_sequencer.sv
// Sequences one program run of the core: hold in reset, release on req, count cycles
// until core_done or the watchdog limit, and arbitrate the data memory write port.
// Ports: clk/reset (sync, active-high); req start; core_done in; core_reset/core_en to
//        the core; busy/done/timeout/cycle_count status; host_*/core_* -> mem_* write port;
//        host_gnt/host_drop arbitration status. Optional step input when
//        RUN_SEQUENCER_SINGLE_STEP_EN is defined (one core_en cycle per step rise).
module run_sequencer
  import run_seq_pkg::*;
#(
  parameter int          CLR_CYCLES = 2,
  parameter int          CNT_W      = CNT_W_DEF,
  parameter int unsigned MAX_CYCLES = MAX_CYCLES_DEF,
  parameter int          AW         = 8,
  parameter int          DW         = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req,
`ifdef RUN_SEQUENCER_SINGLE_STEP_EN
  input  logic             step,
`endif
  input  logic             core_done,
  output logic             core_reset,
  output logic             core_en,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic [CNT_W-1:0] cycle_count,
  input  logic             host_wr_en,
  input  logic [AW-1:0]    host_addr,
  input  logic [DW-1:0]    host_wdata,
  input  logic             core_wr_en,
  input  logic [AW-1:0]    core_addr,
  input  logic [DW-1:0]    core_wdata,
  output logic             mem_wr_en,
  output logic [AW-1:0]    mem_addr,
  output logic [DW-1:0]    mem_wdata,
  output logic             host_gnt,
  output logic             host_drop
);

  localparam int               CLR_W    = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;
  localparam logic [CLR_W-1:0] CLR_LOAD = CLR_W'(CLR_CYCLES - 1);
  localparam logic [CNT_W-1:0] MAX_C    = CNT_W'(MAX_CYCLES);

  run_state_e       state;
  logic [CLR_W-1:0] clr_cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic             run_en;   // core_en value for the next cycle if we stay in RUN

  assign cnt_inc = cycle_count + CNT_W'(1);

`ifdef RUN_SEQUENCER_SINGLE_STEP_EN
  logic step_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      step_q <= 1'b0;
    end else begin
      step_q <= step;
    end
  end

  assign run_en = step && !step_q;
`else
  assign run_en = 1'b1;
`endif

  // All status outputs are registered alongside the state so they always agree with it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      clr_cnt     <= '0;
      core_reset  <= 1'b1;
      core_en     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      timeout     <= 1'b0;
      cycle_count <= '0;
    end else begin
      case (state)
        IDLE, FIN, TOUT: begin
          if (req) begin
            state       <= CLEAR;
            clr_cnt     <= CLR_LOAD;
            cycle_count <= '0;
            core_reset  <= 1'b1;
            busy        <= 1'b1;
            done        <= 1'b0;
            timeout     <= 1'b0;
          end
        end

        // Counter loaded with CLR_CYCLES-1, so CLEAR lasts exactly CLR_CYCLES cycles.
        CLEAR: begin
          if (clr_cnt == '0) begin
            state      <= RUN;
            core_reset <= 1'b0;
            core_en    <= run_en;
          end else begin
            clr_cnt <= clr_cnt - CLR_W'(1);
          end
        end

        // core_done takes priority over the watchdog when both land in the same cycle.
        RUN: begin
          if (core_en) begin
            cycle_count <= cnt_inc;
          end
          if (core_done) begin
            state   <= FIN;
            done    <= 1'b1;
            busy    <= 1'b0;
            core_en <= 1'b0;
          end else if (core_en && (cnt_inc == MAX_C)) begin
            state   <= TOUT;
            timeout <= 1'b1;
            busy    <= 1'b0;
            core_en <= 1'b0;
          end else begin
            core_en <= run_en;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  mem_port_arb #(
    .AW(AW),
    .DW(DW)
  ) u_arb (
    .clk       (clk),
    .reset     (reset),
    .busy      (busy),
    .host_wr_en(host_wr_en),
    .host_addr (host_addr),
    .host_wdata(host_wdata),
    .core_wr_en(core_wr_en),
    .core_addr (core_addr),
    .core_wdata(core_wdata),
    .mem_wr_en (mem_wr_en),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .host_gnt  (host_gnt),
    .host_drop (host_drop)
  );

endmodule
